// File: rtl/regfile_32x64.sv
// 32-entry register file: one write port, two combinational read ports with
// write-through bypass, a hardwired-zero register and asynchronous active-low clear.
module regfile_32x64 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam logic [4:0] ZERO_IDX = ZERO_REG[4:0];

    logic [WIDTH-1:0] regs [32];
    logic [31:0]      write_en;
    logic             bypass_1;
    logic             bypass_2;
    logic [WIDTH-1:0] stage_1 [4];
    logic [WIDTH-1:0] stage_2 [4];

    // One-hot write decode; the zero register never gets an enable.
    always_comb begin
        write_en = '0;
        if (RegWrite) begin
            write_en[WriteRegister] = 1'b1;
        end
        write_en[ZERO_IDX] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (write_en[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Bypass is gated by reset so the outputs read zero throughout a clear.
    assign bypass_1 = reset && RegWrite && (WriteRegister == ReadRegister1)
                      && (WriteRegister != ZERO_IDX);
    assign bypass_2 = reset && RegWrite && (WriteRegister == ReadRegister2)
                      && (WriteRegister != ZERO_IDX);

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            stage_1[g] = regs[{g[1:0], ReadRegister1[2:0]}];
        end
        if (ReadRegister1 == ZERO_IDX) begin
            ReadData1 = '0;
        end else if (bypass_1) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = stage_1[ReadRegister1[4:3]];
        end
    end

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            stage_2[g] = regs[{g[1:0], ReadRegister2[2:0]}];
        end
        if (ReadRegister2 == ZERO_IDX) begin
            ReadData2 = '0;
        end else if (bypass_2) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = stage_2[ReadRegister2[4:3]];
        end
    end

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed scenarios with literal
// expectations plus randomized traffic checked against an array model.
module tb_regfile_32x64;

    localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [63:0] WriteData = '0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [63:0] model [32];

    regfile_32x64 dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    // Model: array of register contents, cleared whenever reset falls.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] <= '0;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model[WriteRegister] <= WriteData;
        end
    end

    function automatic logic [63:0] model_read(input logic [4:0] sel);
        if (sel == 5'd31 || !reset) return 64'h0;
        if (RegWrite && WriteRegister == sel) return WriteData;
        return model[sel];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_rd1", ReadData1, model_read(ReadRegister1));
            check("cycle_rd2", ReadData2, model_read(ReadRegister2));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
        RegWrite = 1'b1;
        WriteRegister = idx;
        WriteData = val;
        cycle();
        RegWrite = 1'b0;
    endtask

    initial begin
        // Reset with a write attempt pending
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        RegWrite = 1'b1;
        WriteRegister = 5'd5;
        WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
        ReadRegister1 = 5'd5;
        #1 check("reset_bypass_off", ReadData1, 64'h0);
        cycle();
        check("reset_no_write", ReadData1, 64'h0);
        RegWrite = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check("post_reset_rd1", ReadData1, 64'h0);
            check("post_reset_rd2", ReadData2, 64'h0);
        end
        cycle();

        // Write every index, then read mirrored pairs
        for (int i = 0; i <= 30; i++) write_reg(5'(i), 64'(i) * STEP);
        for (int i = 0; i <= 30; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(30 - i);
            #1;
            check("all_rd1", ReadData1, 64'(i) * STEP);
            check("all_rd2", ReadData2, 64'(30 - i) * STEP);
        end
        cycle();

        // Zero register
        RegWrite = 1'b1;
        WriteRegister = 5'd31;
        WriteData = 64'hDEAD_BEEF_0000_0001;
        ReadRegister1 = 5'd31;
        #1 check("zero_before", ReadData1, 64'h0);
        cycle();
        RegWrite = 1'b0;
        #1 check("zero_after", ReadData1, 64'h0);

        // Bypass on both ports
        write_reg(5'd7, 64'h11);
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
        #1 check("bypass_old", ReadData1, 64'h11);
        RegWrite = 1'b1;
        WriteRegister = 5'd7;
        WriteData = 64'h22;
        #1;
        check("bypass_rd1_pre", ReadData1, 64'h22);
        check("bypass_rd2_pre", ReadData2, 64'h22);
        cycle();
        RegWrite = 1'b0;
        WriteData = 64'h0;
        #1;
        check("bypass_rd1_post", ReadData1, 64'h22);
        check("bypass_rd2_post", ReadData2, 64'h22);

        // Write disable
        write_reg(5'd3, 64'hA5);
        RegWrite = 1'b0;
        WriteRegister = 5'd3;
        WriteData = 64'h5A;
        ReadRegister1 = 5'd3;
        cycle();
        check("write_disable", ReadData1, 64'hA5);

        // Randomized traffic, biased toward read/write collisions
        for (int n = 0; n < 400; n++) begin
            RegWrite = 1'($urandom_range(0, 1));
            WriteRegister = 5'($urandom_range(0, 31));
            WriteData = {32'($urandom), 32'($urandom)};
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            cycle();
        end
        RegWrite = 1'b0;

        // Mid-cycle asynchronous reset
        for (int i = 1; i <= 30; i++) write_reg(5'(i), {32'($urandom), 32'(i + 1)});
        RegWrite = 1'b1;
        WriteRegister = 5'd4;
        WriteData = 64'h1234;
        ReadRegister1 = 5'd1;
        ReadRegister2 = 5'd30;
        #1 check("pre_reset_rd1", ReadData1, {model[1][63:32], 32'd2});
        #1 reset = 1'b0;
        #1;
        check("async_rd1", ReadData1, 64'h0);
        check("async_rd2", ReadData2, 64'h0);
        ReadRegister1 = 5'd4;
        #1 check("async_bypass_off", ReadData1, 64'h0);
        cycle();
        check("reset_edge_no_write", ReadData1, 64'h0);
        reset = 1'b1;
        RegWrite = 1'b0;
        cycle();
        write_reg(5'd2, 64'h3);
        ReadRegister1 = 5'd2;
        ReadRegister2 = 5'd1;
        #1;
        check("after_reset_rd1", ReadData1, 64'h3);
        check("after_reset_rd2", ReadData2, 64'h0);
        cycle();
        cycle();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_32x64.md
REGFILE_32X64 -- requirements
Module: regfile_32x64

Interface
Parameters
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the data width of every register and data port.
REQ-002 The block SHALL have parameter ZERO_REG, default 31, giving the hardwired-zero register index.

Ports
REQ-003 clk  input  1  Single clock; all register updates occur on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-005 RegWrite  input  1  Write enable for the write port.
REQ-006 WriteRegister  input  5  Destination register index.
REQ-007 WriteData  input  WIDTH  Data to write.
REQ-008 ReadRegister1  input  5  Read port 1 index.
REQ-009 ReadRegister2  input  5  Read port 2 index.
REQ-010 ReadData1  output  WIDTH  Read port 1 data.
REQ-011 ReadData2  output  WIDTH  Read port 2 data.

Function
REQ-012 The block SHALL contain 32 storage registers of WIDTH bits, indices 0-31.
REQ-013 On a rising clk edge with reset=1 and RegWrite=1, the register at WriteRegister SHALL load WriteData, unless WriteRegister equals ZERO_REG.
REQ-014 A write to ZERO_REG SHALL be discarded; ZERO_REG SHALL read 0 at all times.
REQ-015 On a rising clk edge with RegWrite=0, no register SHALL change.
REQ-016 Each write SHALL update exactly one register; all other registers SHALL hold their values.
REQ-017 Reads SHALL be combinational: ReadDataN SHALL reflect the selected register within the same cycle, with no clock latency.
REQ-018 Write-through bypass: when RegWrite=1, WriteRegister=ReadRegisterN and WriteRegister is not ZERO_REG, ReadDataN SHALL equal WriteData during that same cycle, before the edge.
REQ-019 Bypass SHALL apply independently to each port; when both ports select the write target, both ports SHALL return WriteData.
REQ-020 When ReadRegisterN=ZERO_REG, ReadDataN SHALL be 0 regardless of bypass conditions.
REQ-021 The write decode SHALL be a 5-to-32 one-hot enable gated by RegWrite.
REQ-022 Each read port SHALL be a 32:1 WIDTH-bit mux tree built from 8:1 stages selected by ReadRegisterN[2:0], followed by a 4:1 stage selected by ReadRegisterN[4:3].
REQ-023 Storage SHALL be flip-flops with per-register enable; the block SHALL have no latches and no combinational loop through the bypass path.

Reset
REQ-024 While reset=0, all 32 registers SHALL be 0, so both ReadData outputs read 0 (bypass inactive).
REQ-025 Assertion of reset SHALL clear the registers asynchronously, without waiting for a clk edge, including mid-cycle while RegWrite=1.
REQ-026 A rising clk edge while reset=0 SHALL NOT perform a write.
REQ-027 The first write SHALL occur on the first rising clk edge after reset returns to 1.

Verification
REQ-028 Reset: hold reset=0, RegWrite=1, WriteRegister=5, WriteData=64'hFFFF_FFFF_FFFF_FFFF, pulse clk, then release reset -> ReadData1 for index 5 = 0 and all 32 indices read 0.
REQ-029 Write/read all: write index i with value i*64'h0101_0101_0101_0101 for i=0..30, then read all pairs (i, 30-i) -> each port returns its written value.
REQ-030 Zero register: write index 31 with 64'hDEAD_BEEF_0000_0001 and set ReadRegister1=31 in the same cycle -> ReadData1=0 before and after the edge.
REQ-031 Bypass: index 7 holds 64'h11; set RegWrite=1, WriteRegister=7, WriteData=64'h22, ReadRegister1=ReadRegister2=7 -> both ports read 64'h22 before the edge and still read 64'h22 after it with RegWrite=0.
REQ-032 Write disable: index 3 holds 64'hA5; set RegWrite=0, WriteRegister=3, WriteData=64'h5A, pulse clk -> index 3 reads 64'hA5.
REQ-033 Mid-operation reset: after registers 1-30 are loaded, assert reset=0 between clk edges -> both ports read 0 immediately without a clk edge; after release, a write of 64'h3 to index 2 reads back 64'h3 and index 1 reads 0.
